ifetcher_timeout_monitor: RTL and testbench
===========================================

# ifetcher_timeout_monitor

Multi-channel watchdog for outstanding instruction-fetch requests. Each of NCH channels times one in-flight request from a start pulse to a done pulse against a per-request threshold latched at start. An expiry raises a one-cycle pulse and a sticky fatal that only a per-channel clear removes. It sits between the ifetcher request tracker and the core exception/debug logic, and generalises the single free-running fetch timeout counter to multiple channels, programmable limits, pause and restart.

## Interface
Parameters:
- CW, 8: counter and threshold width per channel
- NCH, 4: number of channels, at least 1
- PSW, 4: prescaler width; used only with IFETCHER_TOMON_PRESCALE_EN

Ports:
- iClk  in  1  clock; all state updates on its rising edge
- iReset  in  1  reset, synchronous, active-high
- iStart  in  NCH  per-channel pulse: begin or restart timing
- iDone  in  NCH  per-channel pulse: request completed
- iHold  in  NCH  per-channel level: pause counting while high
- iThreshold  in  CW  timeout limit, shared bus, latched per channel on iStart
- iFatalClr  in  NCH  per-channel pulse: clear sticky expiry
- oBusy  out  NCH  channel is in COUNT
- oTimeoutPulse  out  NCH  one-cycle pulse in the first EXPIRED cycle
- oTimeoutFatal  out  1  OR of all channels in EXPIRED
- oFatalId  out  max(1,$clog2(NCH))  lowest-index EXPIRED channel; 0 when none
- oCounter  out  NCH*CW  packed counters; channel i occupies [i*CW +: CW]

## Operation
- Per-channel FSM with states IDLE, COUNT and EXPIRED.
- IDLE: counter is 0. On iStart: go to COUNT, set counter to 0, latch iThreshold. iDone, iHold and iFatalClr are ignored.
- COUNT, evaluated in priority order:
  1. iDone: go to IDLE and clear counter. iDone beats a same-cycle threshold match and a same-cycle iStart.
  2. iStart: restart. Counter goes to 0 and iThreshold is re-latched.
  3. iHold: counter holds and expiry is suppressed.
  4. counter == latched threshold and tick: go to EXPIRED. Counter holds at the threshold.
  5. Otherwise, on tick: counter + 1.
- The counter never exceeds the latched threshold, so it never wraps. A threshold of all-ones is legal.
- EXPIRED: counter frozen. iStart and iDone are ignored, so a late done is not an error. iFatalClr sends the channel to IDLE and clears the counter. iFatalClr beats a same-cycle iStart, which is dropped.
- oTimeoutPulse is a register, high exactly in the first EXPIRED cycle.
- oTimeoutFatal and oFatalId are combinational from the state registers.
- Channels are fully independent. Any combination of simultaneous events across channels is legal.

## Timing
- Reset: iReset high at an edge puts every channel in IDLE. All counters, latched thresholds, oBusy, oTimeoutPulse, oTimeoutFatal and oFatalId are 0. Reset mid-COUNT or mid-EXPIRED discards that state with no pulse.
- iStart sampled in cycle k gives oBusy = 1 and counter = 0 in cycle k+1.
- Without hold, counter = n in cycle k+1+n.
- With threshold T: counter = T in cycle k+1+T. EXPIRED, oTimeoutPulse and oTimeoutFatal are all 1 in cycle k+2+T.
- T = 0 expires in cycle k+2.
- Each held cycle delays expiry by one cycle.
- iDone sampled in cycle j gives oBusy = 0 and counter = 0 in cycle j+1.
- iFatalClr sampled in cycle j clears oTimeoutFatal in cycle j+1, provided no other channel is expired.

## Configuration
- IFETCHER_TOMON_PRESCALE_EN defined:
  - A free-running PSW-bit prescaler, cleared by iReset, generates a tick when it equals all-ones, i.e. once every 2^PSW cycles.
  - Counting and the expiry check advance only on tick. Start, done and clear still act every cycle.
- Not defined: tick is constantly 1, PSW is unused and no prescaler register exists.

## Structure
- Shared package ifetcher_pkg holds:
  - state encoding localparams: IDLE = 2'b00, COUNT = 2'b01, EXPIRED = 2'b10
  - the FSM as its own typedef
  - the oFatalId width helper function
- Sub-module ifetcher_timeout_channel: one FSM, counter, threshold register and pulse register. It takes tick as an input.
- Top level: instantiates NCH channels, the prescaler (under the macro), the lowest-index priority encoder, and the output packing.

## Test plan
- Reset then iStart[0] with iThreshold = 5 in cycle 0 -> counter 0..5 in cycles 1..6; oTimeoutPulse[0] = 1 only in cycle 7; oTimeoutFatal stays 1; oFatalId = 0.
- iStart[1] with T = 10, iDone[1] in the cycle where counter = 10 -> no expiry, oBusy[1] = 0 next cycle; late iDone while EXPIRED on another channel -> ignored.
- iStart[2] with T = 3, iHold[2] high for 4 cycles mid-count -> expiry 4 cycles later than the unheld case; restart via iStart[2] at counter = 2 with T = 1 -> expiry 3 cycles later.
- Channels 1 and 3 expired -> oFatalId = 1; iFatalClr[1] -> oFatalId = 3; iFatalClr[3] together with iStart[3] -> channel 3 in IDLE, oTimeoutFatal = 0.
- CW = 4, T = 15 -> counter saturates at 15 with no wrap, then expires; iReset mid-COUNT -> all outputs 0 next cycle with no pulse.
- IFETCHER_TOMON_PRESCALE_EN with PSW = 2 and T = 2 -> counter advances every 4th cycle; expiry occurs on the third tick after start.

Source files
------------

// File: rtl/ifetcher_pkg.sv
// Shared definitions for the instruction-fetch timeout monitor: channel FSM encoding and
// the fatal-id width helper.
package ifetcher_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COUNT   = 2'b01;
    localparam logic [1:0] EXPIRED = 2'b10;

    typedef logic [1:0] tomon_state_t;

    function automatic int fatal_id_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ifetcher_timeout_monitor_if.sv
// Request/status bundle between the fetch tracker (master) and the timeout monitor (slave).
// Pure wiring; no flow control, every field is sampled or driven each cycle.
interface ifetcher_timeout_monitor_if #(
    parameter int CW  = 8,
    parameter int NCH = 4
);
    import ifetcher_pkg::*;

    localparam int FIDW = fatal_id_w(NCH);

    logic [NCH-1:0]    iStart;
    logic [NCH-1:0]    iDone;
    logic [NCH-1:0]    iHold;
    logic [CW-1:0]     iThreshold;
    logic [NCH-1:0]    iFatalClr;
    logic [NCH-1:0]    oBusy;
    logic [NCH-1:0]    oTimeoutPulse;
    logic              oTimeoutFatal;
    logic [FIDW-1:0]   oFatalId;
    logic [NCH*CW-1:0] oCounter;

    modport master (
        output iStart, iDone, iHold, iThreshold, iFatalClr,
        input  oBusy, oTimeoutPulse, oTimeoutFatal, oFatalId, oCounter
    );

    modport slave (
        input  iStart, iDone, iHold, iThreshold, iFatalClr,
        output oBusy, oTimeoutPulse, oTimeoutFatal, oFatalId, oCounter
    );

endinterface

// File: rtl/ifetcher_timeout_channel.sv
// One watchdog channel: IDLE/COUNT/EXPIRED FSM, counter, latched threshold, expiry pulse.
// State visible one cycle after the sampled event; no backpressure, events act every cycle.
module ifetcher_timeout_channel #(
    parameter int CW = 8
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          tick_i,
    input  logic          start_i,
    input  logic          done_i,
    input  logic          hold_i,
    input  logic          fatal_clr_i,
    input  logic [CW-1:0] thresh_i,
    output logic          busy_o,
    output logic          expired_o,
    output logic          pulse_o,
    output logic [CW-1:0] count_o
);
    import ifetcher_pkg::*;

    tomon_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] thr_q, thr_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                    thr_d   = thresh_i;
                end
            end
            COUNT: begin
                // Done wins over restart and over a same-cycle threshold match.
                if (done_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start_i) begin
                    cnt_d = '0;
                    thr_d = thresh_i;
                end else if (!hold_i && tick_i) begin
                    if (cnt_q == thr_q) begin
                        state_d = EXPIRED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            EXPIRED: begin
                if (fatal_clr_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = (state_q == COUNT) && (state_d == EXPIRED);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            thr_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            pulse_q <= pulse_d;
        end
    end

    assign busy_o    = (state_q == COUNT);
    assign expired_o = (state_q == EXPIRED);
    assign pulse_o   = pulse_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/ifetcher_timeout_monitor.sv
// NCH-channel fetch timeout watchdog; IFETCHER_TOMON_PRESCALE_EN adds a 2^PSW tick prescaler.
// Outputs registered per channel, fatal/id combinational; no backpressure.
module ifetcher_timeout_monitor #(
    parameter int CW  = 8,
    parameter int NCH = 4,
    parameter int PSW = 4
) (
    input logic                        iClk,
    input logic                        iReset,
    ifetcher_timeout_monitor_if.slave  bus
);
    import ifetcher_pkg::*;

    localparam int FIDW = fatal_id_w(NCH);

    logic              tick;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    expired;
    logic [NCH-1:0]    pulse;
    logic [NCH*CW-1:0] counters;
    logic [FIDW-1:0]   fatal_id;

`ifdef IFETCHER_TOMON_PRESCALE_EN
    logic [PSW-1:0] presc_q, presc_d;

    assign presc_d = presc_q + PSW'(1);
    assign tick    = &presc_q;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Without the prescaler PSW has no hardware; this keeps the parameter referenced.
    logic [PSW-1:0] unused_psw;
    assign unused_psw = '0;
    assign tick       = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ifetcher_timeout_channel #(.CW(CW)) u_ch (
            .iClk        (iClk),
            .iReset      (iReset),
            .tick_i      (tick),
            .start_i     (bus.iStart[i]),
            .done_i      (bus.iDone[i]),
            .hold_i      (bus.iHold[i]),
            .fatal_clr_i (bus.iFatalClr[i]),
            .thresh_i    (bus.iThreshold),
            .busy_o      (busy[i]),
            .expired_o   (expired[i]),
            .pulse_o     (pulse[i]),
            .count_o     (counters[i*CW +: CW])
        );
    end

    // Scan from the top so the lowest expired index is the last write.
    always_comb begin
        fatal_id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (expired[i]) begin
                fatal_id = FIDW'(i);
            end
        end
    end

    assign bus.oBusy         = busy;
    assign bus.oTimeoutPulse = pulse;
    assign bus.oTimeoutFatal = |expired;
    assign bus.oFatalId      = fatal_id;
    assign bus.oCounter      = counters;

endmodule

// File: tb/tb_ifetcher_timeout_monitor.sv
// Vector table of per-cycle stimulus and expected outputs, checked through a push/pop scoreboard.
// Default build runs the functional table; the prescaler build runs the tick-rate table.
module tb_ifetcher_timeout_monitor;
    import ifetcher_pkg::*;

    localparam int CW  = 4;
    localparam int NCH = 4;
    localparam int PSW = 2;

    typedef struct {
        logic           rst;
        logic [NCH-1:0] start;
        logic [NCH-1:0] done;
        logic [NCH-1:0] hold;
        logic [NCH-1:0] clr;
        logic [CW-1:0]  thr;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] pulse;
        logic           fatal;
        logic [1:0]     fid;
        int             ch;    // channel whose counter is checked; -1 checks all counters are 0
        logic [CW-1:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    ifetcher_timeout_monitor_if #(.CW(CW), .NCH(NCH)) bus ();

    ifetcher_timeout_monitor #(.CW(CW), .NCH(NCH), .PSW(PSW)) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] st, input logic [3:0] dn,
                       input logic [3:0] hd, input logic [3:0] cl, input logic [3:0] th,
                       input logic [3:0] bz, input logic [3:0] pl, input logic ft,
                       input logic [1:0] fi, input int ch, input logic [3:0] cn);
        vec_t v;
        v.rst = r;  v.start = st; v.done = dn; v.hold = hd; v.clr = cl; v.thr = th;
        v.busy = bz; v.pulse = pl; v.fatal = ft; v.fid = fi; v.ch = ch; v.cnt = cn;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [3:0] bz, input logic [3:0] pl, input logic ft,
                        input logic [1:0] fi, input int ch, input logic [3:0] cn);
        add(1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'd0, bz, pl, ft, fi, ch, cn);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h, want %0h", name, idx, act, req);
        end
    endtask

    task automatic compare(input vec_t e, input int idx);
        chk("busy",  idx, 32'(bus.oBusy),         32'(e.busy));
        chk("pulse", idx, 32'(bus.oTimeoutPulse), 32'(e.pulse));
        chk("fatal", idx, 32'(bus.oTimeoutFatal), 32'(e.fatal));
        chk("fid",   idx, 32'(bus.oFatalId),      32'(e.fid));
        if (e.ch < 0) begin
            chk("counters", idx, 32'(bus.oCounter), 32'd0);
        end else begin
            chk("counter", idx, 32'(bus.oCounter[e.ch*CW +: CW]), 32'(e.cnt));
        end
    endtask

    task automatic build_functional();
        // ch0, T=5: counter 0..5, pulse once, fatal sticky
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        add(0, 4'b0001, 0, 0, 0, 5, 4'b0001, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 5; n++) idle(4'b0001, 0, 0, 0, 0, 4'(n));
        idle(0, 4'b0001, 1, 0, 0, 5);
        idle(0, 0, 1, 0, 0, 5);
        idle(0, 0, 1, 0, 0, 5);
        // ch1, T=10, done on the matching cycle; late done/start on expired ch0 ignored
        add(0, 4'b0010, 0, 0, 0, 10, 4'b0010, 0, 1, 0, 1, 0);
        add(0, 0, 4'b0001, 0, 0, 0, 4'b0010, 0, 1, 0, 1, 1);
        add(0, 4'b0001, 0, 0, 0, 3, 4'b0010, 0, 1, 0, 1, 2);
        for (int n = 3; n <= 10; n++) idle(4'b0010, 0, 1, 0, 1, 4'(n));
        add(0, 0, 4'b0010, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle(0, 0, 1, 0, 1, 0);
        idle(0, 0, 1, 0, 0, 5);
        add(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        // ch2, T=3 with four held cycles
        add(0, 4'b0100, 0, 0, 0, 3, 4'b0100, 0, 0, 0, 2, 0);
        idle(4'b0100, 0, 0, 0, 2, 1);
        for (int n = 0; n < 4; n++) add(0, 0, 0, 4'b0100, 0, 0, 4'b0100, 0, 0, 0, 2, 1);
        idle(4'b0100, 0, 0, 0, 2, 2);
        idle(4'b0100, 0, 0, 0, 2, 3);
        idle(0, 4'b0100, 1, 2, 2, 3);
        add(0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 2, 0);
        // ch2 restart at counter 2 with T=1
        add(0, 4'b0100, 0, 0, 0, 3, 4'b0100, 0, 0, 0, 2, 0);
        idle(4'b0100, 0, 0, 0, 2, 1);
        idle(4'b0100, 0, 0, 0, 2, 2);
        add(0, 4'b0100, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 2, 0);
        idle(4'b0100, 0, 0, 0, 2, 1);
        idle(0, 4'b0100, 1, 2, 2, 1);
        add(0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 2, 0);
        // ch1 and ch3 expire together at T=0; priority id, clear beats start
        add(0, 4'b1010, 0, 0, 0, 0, 4'b1010, 0, 0, 0, 1, 0);
        idle(0, 4'b1010, 1, 1, 3, 0);
        add(0, 0, 0, 0, 4'b0010, 0, 0, 0, 1, 3, 1, 0);
        add(0, 4'b1000, 0, 0, 4'b1000, 5, 0, 0, 0, 0, 3, 0);
        idle(0, 0, 0, 0, 3, 0);
        // done beats a same-cycle restart
        add(0, 4'b0001, 0, 0, 0, 2, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, 0, 0, 7, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0);
        // all-ones threshold reaches 15 without wrapping, then expires
        add(0, 4'b0001, 0, 0, 0, 15, 4'b0001, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 15; n++) idle(4'b0001, 0, 0, 0, 0, 4'(n));
        idle(0, 4'b0001, 1, 0, 0, 15);
        idle(0, 0, 1, 0, 0, 15);
        // reset mid-COUNT (ch1) with ch0 still expired
        add(0, 4'b0010, 0, 0, 0, 8, 4'b0010, 0, 1, 0, 1, 0);
        idle(4'b0010, 0, 1, 0, 1, 1);
        idle(4'b0010, 0, 1, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        idle(0, 0, 0, 0, -1, 0);
        // reset on the cycle an expiry would land suppresses the pulse
        add(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        idle(0, 0, 0, 0, -1, 0);
    endtask

    task automatic build_prescaled();
        // tick every 4th cycle; T=2 expires on the third tick after start
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        add(0, 4'b0001, 0, 0, 0, 2, 4'b0001, 0, 0, 0, 0, 0);
        for (int n = 0; n < 2; n++) idle(4'b0001, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) idle(4'b0001, 0, 0, 0, 0, 1);
        for (int n = 0; n < 4; n++) idle(4'b0001, 0, 0, 0, 0, 2);
        idle(0, 4'b0001, 1, 0, 0, 2);
        idle(0, 0, 1, 0, 0, 2);
    endtask

    initial begin
        bus.iStart     = '0;
        bus.iDone      = '0;
        bus.iHold      = '0;
        bus.iFatalClr  = '0;
        bus.iThreshold = '0;
`ifdef IFETCHER_TOMON_PRESCALE_EN
        build_prescaled();
`else
        build_functional();
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) compare(exp_q.pop_front(), i - 1);
            rst            = tbl[i].rst;
            bus.iStart     = tbl[i].start;
            bus.iDone      = tbl[i].done;
            bus.iHold      = tbl[i].hold;
            bus.iFatalClr  = tbl[i].clr;
            bus.iThreshold = tbl[i].thr;
            exp_q.push_back(tbl[i]);
        end
        @(negedge clk);
        if (exp_q.size() > 0) compare(exp_q.pop_front(), tbl.size() - 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
